// File: rtl/lock_pkg.sv
// Shared encodings and elaboration-time helpers for the combination lock sequencer.
package lock_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_OPEN    = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;
   localparam logic [2:0] S_PROGRAM = 3'd5;

   // Bits needed to hold any value in 0..max_val (at least one bit).
   function automatic int unsigned width_for(input int unsigned max_val);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((max_val >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Pushbutton front end: two-flop synchronizer, level sampled only on tick for
// debounce, and a one-cycle press pulse on a sampled high-to-low transition.
module key_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic btn_ni,
   output logic press_o
);

   logic [1:0] sync_q;
   logic       samp_q;

   // Idle level of an active-low button is high, so reset there to avoid a phantom press.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
         samp_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], btn_ni};
         if (tick_i) samp_q <= sync_q[1];
      end
   end

   assign press_o = tick_i & samp_q & ~sync_q[1];

endmodule

// File: rtl/lock_controller.sv
// Combination lock sequencer: digit collection, verdict, fail counting with
// timed lockout, auto-relock and on-board re-programming of the combination.
module lock_controller
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter logic [DIGIT_W*DIGITS-1:0] DEFAULT_COMBO = 16'h8421,
   parameter int unsigned TICK_DIV      = 50000,
   parameter int unsigned MAX_FAILS     = 3,
   parameter int unsigned LOCKOUT_TICKS = 10000,
   parameter int unsigned OPEN_TICKS    = 5000,
   parameter int unsigned ENTRY_TICKS   = 5000
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [3:0] SW,
   input  logic       ENTER_N,
   input  logic       PROG_N,
   output logic       UNLOCK,
   output logic       LOCKED_OUT,
   output logic [2:0] STATE,
   output logic [3:0] DIGIT_CNT,
   output logic [2:0] FAIL_CNT,
   output logic [3:0] LAST_DIGIT
);

   localparam int unsigned CW   = DIGIT_W * DIGITS;
   localparam int unsigned TMAX = max3(LOCKOUT_TICKS, OPEN_TICKS, ENTRY_TICKS);
   localparam int unsigned TW   = width_for(TMAX);
   localparam int unsigned PW   = width_for(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    state_q, state_d;
   logic [3:0]    digit_cnt_q, digit_cnt_d;
   logic [2:0]    fail_q, fail_d;
   logic [3:0]    last_q, last_d;
   logic [CW-1:0] entry_q, entry_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic [CW-1:0] combo_q, combo_d;
   logic [CW-1:0] entry_shift, shadow_shift;
   logic          tick, enter_press, prog_press, last_digit;

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   key_sync_edge u_enter (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .tick_i  (tick),
      .btn_ni  (ENTER_N),
      .press_o (enter_press)
   );

   key_sync_edge u_prog (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .tick_i  (tick),
      .btn_ni  (PROG_N),
      .press_o (prog_press)
   );

   assign entry_shift  = (entry_q << DIGIT_W) | CW'(SW);
   assign shadow_shift = (shadow_q << DIGIT_W) | CW'(SW);
   assign last_digit   = (digit_cnt_q == 4'(DIGITS - 1));

   always_comb begin
      state_d     = state_q;
      timer_d     = (tick && timer_q != TW'(TMAX)) ? timer_q + TW'(1) : timer_q;
      digit_cnt_d = digit_cnt_q;
      fail_d      = fail_q;
      last_d      = last_q;
      entry_d     = entry_q;
      shadow_d    = shadow_q;
      combo_d     = combo_q;

      case (state_q)
         S_IDLE: begin
            if (enter_press) begin
               entry_d     = entry_shift;
               last_d      = SW;
               digit_cnt_d = 4'd1;
               state_d     = (DIGITS == 1) ? S_CHECK : S_ENTRY;
            end
         end
         S_ENTRY: begin
            // A press on the timeout tick takes priority and restarts the timer.
            if (enter_press) begin
               entry_d     = entry_shift;
               last_d      = SW;
               digit_cnt_d = digit_cnt_q + 4'd1;
               timer_d     = '0;
               if (last_digit) state_d = S_CHECK;
            end else if (tick && timer_q == TW'(ENTRY_TICKS - 1)) begin
               digit_cnt_d = '0;
               state_d     = S_IDLE;
            end
         end
         S_CHECK: begin
            digit_cnt_d = '0;
            if (entry_q == combo_q) begin
               fail_d  = '0;
               state_d = S_OPEN;
            end else if (fail_q >= 3'(MAX_FAILS - 1)) begin
               fail_d  = 3'(MAX_FAILS);
               state_d = S_LOCKOUT;
            end else begin
               fail_d  = fail_q + 3'd1;
               state_d = S_IDLE;
            end
         end
         S_OPEN: begin
            if (prog_press) begin
               digit_cnt_d = '0;
               state_d     = S_PROGRAM;
            end else if (enter_press) begin
               state_d = S_IDLE;
            end else if (tick && timer_q == TW'(OPEN_TICKS - 1)) begin
               state_d = S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (tick && timer_q == TW'(LOCKOUT_TICKS - 1)) begin
               fail_d  = '0;
               state_d = S_IDLE;
            end
         end
         S_PROGRAM: begin
            // The live combination is only replaced once a full sequence is in.
            if (enter_press) begin
               shadow_d    = shadow_shift;
               last_d      = SW;
               timer_d     = '0;
               if (last_digit) begin
                  combo_d     = shadow_shift;
                  digit_cnt_d = '0;
                  state_d     = S_IDLE;
               end else begin
                  digit_cnt_d = digit_cnt_q + 4'd1;
               end
            end else if (tick && timer_q == TW'(ENTRY_TICKS - 1)) begin
               digit_cnt_d = '0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            digit_cnt_d = '0;
            state_d     = S_IDLE;
         end
      endcase

      if (state_d != state_q) timer_d = '0;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         presc_q     <= '0;
         timer_q     <= '0;
         state_q     <= S_IDLE;
         digit_cnt_q <= '0;
         fail_q      <= '0;
         last_q      <= '0;
         entry_q     <= '0;
         shadow_q    <= '0;
         combo_q     <= DEFAULT_COMBO;
      end else begin
         presc_q     <= presc_d;
         timer_q     <= timer_d;
         state_q     <= state_d;
         digit_cnt_q <= digit_cnt_d;
         fail_q      <= fail_d;
         last_q      <= last_d;
         entry_q     <= entry_d;
         shadow_q    <= shadow_d;
         combo_q     <= combo_d;
      end
   end

   assign UNLOCK     = (state_q == S_OPEN) || (state_q == S_PROGRAM);
   assign LOCKED_OUT = (state_q == S_LOCKOUT);
   assign STATE      = state_q;
   assign DIGIT_CNT  = digit_cnt_q;
   assign FAIL_CNT   = fail_q;
   assign LAST_DIGIT = last_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: tick-indexed behavioural model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_lock_controller;

   localparam int TD = 4;
   localparam int LT = 20;
   localparam int OT = 10;
   localparam int ET = 8;
   localparam int ND = 4;
   localparam int MF = 3;
   localparam logic [15:0] DEF = 16'h8421;

   localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_LOCKOUT = 4, M_PROGRAM = 5;

   logic       clk = 1'b0;
   logic       rst_n, enter_n, prog_n;
   logic [3:0] sw;
   logic       unlock, locked_out;
   logic [2:0] state, fail_cnt;
   logic [3:0] digit_cnt, last_digit;

   always #5 clk = ~clk;

   lock_controller #(
      .DIGITS        (ND),
      .DEFAULT_COMBO (DEF),
      .TICK_DIV      (TD),
      .MAX_FAILS     (MF),
      .LOCKOUT_TICKS (LT),
      .OPEN_TICKS    (OT),
      .ENTRY_TICKS   (ET)
   ) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .SW         (sw),
      .ENTER_N    (enter_n),
      .PROG_N     (prog_n),
      .UNLOCK     (unlock),
      .LOCKED_OUT (locked_out),
      .STATE      (state),
      .DIGIT_CNT  (digit_cnt),
      .FAIL_CNT   (fail_cnt),
      .LAST_DIGIT (last_digit)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: deadlines are absolute tick indices rather than running counters.
   bit m_valid = 1'b0;
   int m_cyc, m_tick_idx, m_deadline, m_mode, m_fail, m_last, m_press_tick;
   bit m_e1, m_e2, m_elast, m_p1, m_p2, m_plast;
   bit m_tk, m_pe, m_pp, m_match;
   int m_digits[$];
   int m_shadow[$];
   int m_combo[ND];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b1;
         m_cyc = 0; m_tick_idx = 0; m_deadline = 0; m_press_tick = 0;
         m_mode = M_IDLE; m_fail = 0; m_last = 0;
         m_e1 = 1; m_e2 = 1; m_elast = 1; m_p1 = 1; m_p2 = 1; m_plast = 1;
         m_digits.delete(); m_shadow.delete();
         for (int i = 0; i < ND; i++) m_combo[i] = int'((DEF >> (4 * (ND - 1 - i))) & 16'hF);
      end else begin
         m_tk = (m_cyc % TD) == (TD - 1);
         m_cyc++;
         m_pe = m_tk && m_elast && !m_e2;
         m_pp = m_tk && m_plast && !m_p2;
         if (m_tk) begin
            m_elast = m_e2; m_plast = m_p2; m_tick_idx++;
         end
         m_e2 = m_e1; m_e1 = enter_n; m_p2 = m_p1; m_p1 = prog_n;
         if (m_pe) m_press_tick = m_tick_idx;
         case (m_mode)
            M_IDLE: if (m_pe) begin
               m_digits.delete(); m_digits.push_back(int'(sw)); m_last = int'(sw);
               if (m_digits.size() == ND) m_mode = M_CHECK;
               else begin m_mode = M_ENTRY; m_deadline = m_tick_idx + ET; end
            end
            M_ENTRY: if (m_pe) begin
               m_digits.push_back(int'(sw)); m_last = int'(sw);
               if (m_digits.size() == ND) m_mode = M_CHECK;
               else m_deadline = m_tick_idx + ET;
            end else if (m_tk && m_tick_idx == m_deadline) begin
               m_mode = M_IDLE; m_digits.delete();
            end
            M_CHECK: begin
               m_match = 1'b1;
               for (int i = 0; i < ND; i++) if (m_digits[i] != m_combo[i]) m_match = 1'b0;
               m_digits.delete();
               if (m_match) begin
                  m_mode = M_OPEN; m_fail = 0; m_deadline = m_tick_idx + OT;
               end else begin
                  m_fail++;
                  if (m_fail >= MF) begin
                     m_fail = MF; m_mode = M_LOCKOUT; m_deadline = m_tick_idx + LT;
                  end else m_mode = M_IDLE;
               end
            end
            M_OPEN: if (m_pp) begin
               m_mode = M_PROGRAM; m_shadow.delete(); m_deadline = m_tick_idx + ET;
            end else if (m_pe) m_mode = M_IDLE;
            else if (m_tk && m_tick_idx == m_deadline) m_mode = M_IDLE;
            M_LOCKOUT: if (m_tk && m_tick_idx == m_deadline) begin
               m_mode = M_IDLE; m_fail = 0;
            end
            M_PROGRAM: if (m_pe) begin
               m_shadow.push_back(int'(sw)); m_last = int'(sw);
               if (m_shadow.size() == ND) begin
                  for (int i = 0; i < ND; i++) m_combo[i] = m_shadow[i];
                  m_shadow.delete(); m_mode = M_IDLE;
               end else m_deadline = m_tick_idx + ET;
            end else if (m_tk && m_tick_idx == m_deadline) begin
               m_mode = M_IDLE; m_shadow.delete();
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   logic       x_ul, x_lo;
   logic [3:0] x_dc;

   always @(negedge clk) begin
      if (m_valid) begin
         x_ul = (m_mode == M_OPEN) || (m_mode == M_PROGRAM);
         x_lo = (m_mode == M_LOCKOUT);
         x_dc = (m_mode == M_PROGRAM) ? 4'(m_shadow.size()) : 4'(m_digits.size());
         n_vec++;
         if (state !== 3'(m_mode) || unlock !== x_ul || locked_out !== x_lo ||
             digit_cnt !== x_dc || fail_cnt !== 3'(m_fail) || last_digit !== 4'(m_last)) begin
            n_err++;
            $display("FAIL cycle_check @%0t: got st=%0d ul=%b lo=%b dc=%0d fc=%0d ld=%0d, exp st=%0d ul=%b lo=%b dc=%0d fc=%0d ld=%0d",
                     $time, state, unlock, locked_out, digit_cnt, fail_cnt, last_digit,
                     m_mode, x_ul, x_lo, x_dc, m_fail, m_last);
         end
      end
   end

   int run_len = 0;
   int last_run = 0;
   always @(negedge clk) begin
      if (unlock === 1'b1) run_len++;
      else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int n;
      n = 0;
      while (int'(state) != s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(state), s);
   endtask

   task automatic press(input logic [3:0] d);
      @(negedge clk);
      sw = d; enter_n = 1'b0;
      repeat (TD + 1) @(negedge clk);
      enter_n = 1'b1;
      repeat (TD + 1) @(negedge clk);
   endtask

   task automatic prog_press();
      @(negedge clk);
      prog_n = 1'b0;
      repeat (TD + 1) @(negedge clk);
      prog_n = 1'b1;
      repeat (TD + 1) @(negedge clk);
   endtask

   task automatic both_press();
      @(negedge clk);
      enter_n = 1'b0; prog_n = 1'b0;
      repeat (TD + 1) @(negedge clk);
      enter_n = 1'b1; prog_n = 1'b1;
      repeat (TD + 1) @(negedge clk);
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 0; i < 4; i++) press(c[15 - 4 * i -: 4]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_unlock"}, int'(unlock), 0);
      chk({tag, "_locked"}, int'(locked_out), 0);
      chk({tag, "_dcnt"}, int'(digit_cnt), 0);
      chk({tag, "_fcnt"}, int'(fail_cnt), 0);
      chk({tag, "_last"}, int'(last_digit), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, n, rises;
      logic [3:0] prev_dc;
      rst_n = 1'b0; enter_n = 1'b1; prog_n = 1'b1; sw = 4'd0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;

      // 1: correct code, digit count, auto-relock after OT ticks
      press(4'h8); chk("t1_dcnt1", int'(digit_cnt), 1); chk("t1_entry", int'(state), 1);
      press(4'h4); chk("t1_dcnt2", int'(digit_cnt), 2);
      press(4'h2); chk("t1_dcnt3", int'(digit_cnt), 3);
      press(4'h1);
      chk("t1_unlock", int'(unlock), 1); chk("t1_open", int'(state), 3);
      chk("t1_dcnt0", int'(digit_cnt), 0); chk("t1_last", int'(last_digit), 1);
      wait_state(0, 80, "t1_relock");
      @(negedge clk);
      chk("t1_open_cycles", last_run, 39);

      // 2: wrong code three times, lockout ignores input, then recovers
      press(4'h0); press(4'h4); press(4'h2);
      chk("t2_no_verdict", int'(state), 1); chk("t2_no_unlock", int'(unlock), 0);
      press(4'h1);
      chk("t2_idle", int'(state), 0); chk("t2_fail1", int'(fail_cnt), 1);
      enter_code(16'h0421); chk("t2_fail2", int'(fail_cnt), 2);
      enter_code(16'h0421);
      chk("t2_locked", int'(locked_out), 1); chk("t2_fail3", int'(fail_cnt), 3);
      enter_code(16'h8421);
      chk("t2_still_locked", int'(state), 4); chk("t2_ignored", int'(digit_cnt), 0);
      wait_state(0, 100, "t2_lockout_end");
      chk("t2_fail_clr", int'(fail_cnt), 0); chk("t2_unlocked_out", int'(locked_out), 0);

      // 3: entry timeout keeps FAIL_CNT; press on the timeout tick wins
      enter_code(16'h0421);
      press(4'h8); press(4'h4);
      repeat (40) @(negedge clk);
      chk("t3_timeout_idle", int'(state), 0); chk("t3_timeout_dcnt", int'(digit_cnt), 0);
      chk("t3_fail_kept", int'(fail_cnt), 1);
      press(4'h8); press(4'h4);
      t0 = m_press_tick; n = 0;
      while (m_tick_idx < t0 + ET - 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      sw = 4'h2; enter_n = 1'b0;
      repeat (TD + 1) @(negedge clk);
      enter_n = 1'b1;
      repeat (TD + 1) @(negedge clk);
      chk("t3_race_entry", int'(state), 1); chk("t3_race_dcnt", int'(digit_cnt), 3);
      wait_state(0, 60, "t3_race_timeout");

      // 4: programming, aborted programming, PROG/ENTER priority, manual relock
      enter_code(16'h8421); chk("t4_open", int'(state), 3);
      prog_press(); chk("t4_prog", int'(state), 5); chk("t4_prog_unlock", int'(unlock), 1);
      press(4'h3); press(4'h3);
      wait_state(0, 60, "t4_prog_abort");
      enter_code(16'h8421); chk("t4_combo_kept", int'(unlock), 1);
      prog_press(); enter_code(16'h3333); chk("t4_prog_done", int'(state), 0);
      enter_code(16'h8421); chk("t4_old_fails", int'(state), 0); chk("t4_old_fcnt", int'(fail_cnt), 1);
      enter_code(16'h3333); chk("t4_new_opens", int'(state), 3);
      both_press(); chk("t4_prog_wins", int'(state), 5);
      enter_code(16'h3333); chk("t4_reprog_done", int'(state), 0);
      enter_code(16'h3333); chk("t4_open_again", int'(state), 3);
      press(4'h7); chk("t4_manual_relock", int'(state), 0); chk("t4_last_kept", int'(last_digit), 3);

      // 5: held button gives one digit; short glitch between ticks gives none
      @(negedge clk);
      sw = 4'h5; enter_n = 1'b0; rises = 0; prev_dc = digit_cnt;
      repeat (50 * TD) begin
         @(negedge clk);
         if (prev_dc == 4'd0 && digit_cnt == 4'd1) rises++;
         prev_dc = digit_cnt;
      end
      enter_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t5_one_digit", rises, 1); chk("t5_idle", int'(state), 0); chk("t5_last", int'(last_digit), 5);
      t0 = m_tick_idx; n = 0;
      while (m_tick_idx == t0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      sw = 4'h9; enter_n = 1'b0;
      @(negedge clk);
      enter_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("t5_glitch_dcnt", int'(digit_cnt), 0); chk("t5_glitch_last", int'(last_digit), 5);

      // 6: reset aborts LOCKOUT and PROGRAM and restores the default combination
      enter_code(16'h0421); enter_code(16'h0421); enter_code(16'h0421);
      chk("t6_locked", int'(locked_out), 1);
      do_reset(); chk_zero("t6_rst_lockout");
      rst_n = 1'b1;
      enter_code(16'h8421); chk("t6_default_combo", int'(unlock), 1);
      prog_press(); press(4'h3); press(4'h3);
      chk("t6_in_prog", int'(state), 5);
      do_reset(); chk_zero("t6_rst_prog");
      rst_n = 1'b1;
      enter_code(16'h8421); chk("t6_default_combo2", int'(unlock), 1);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
